ahmes_control: RTL

AHMES_CONTROL -- requirements
Module: ahmes_control

---
 rtl/ahmes_pkg.sv | 124 ++++++++++++
 rtl/ahmes_flags.sv | 17 +
 rtl/ahmes_control.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ahmes_pkg.sv
// Shared definitions for the Ahmes control unit: ALU codes, opcodes, state type and decode helpers.
// Defining AHMES_XOR_EN makes opcode C0 a two-byte XOR; otherwise it decodes as NOP.
package ahmes_pkg;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_NOT = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_ROL = 4'b0111;
  localparam logic [3:0] ALU_ROR = 4'b1000;
  localparam logic [3:0] ALU_SHL = 4'b1001;
  localparam logic [3:0] ALU_SHR = 4'b1010;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_STA = 8'h10;
  localparam logic [7:0] OP_LDA = 8'h20;
  localparam logic [7:0] OP_ADD = 8'h30;
  localparam logic [7:0] OP_OR  = 8'h40;
  localparam logic [7:0] OP_AND = 8'h50;
  localparam logic [7:0] OP_NOT = 8'h60;
  localparam logic [7:0] OP_SUB = 8'h70;
  localparam logic [7:0] OP_JMP = 8'h80;
  localparam logic [7:0] OP_JN  = 8'h90;
  localparam logic [7:0] OP_JP  = 8'h94;
  localparam logic [7:0] OP_JV  = 8'h98;
  localparam logic [7:0] OP_JNV = 8'h9C;
  localparam logic [7:0] OP_JZ  = 8'hA0;
  localparam logic [7:0] OP_JNZ = 8'hA4;
  localparam logic [7:0] OP_JC  = 8'hB0;
  localparam logic [7:0] OP_JNC = 8'hB4;
  localparam logic [7:0] OP_JB  = 8'hB8;
  localparam logic [7:0] OP_JNB = 8'hBC;
  localparam logic [7:0] OP_XOR = 8'hC0;
  localparam logic [7:0] OP_SHR = 8'hE0;
  localparam logic [7:0] OP_SHL = 8'hE1;
  localparam logic [7:0] OP_ROR = 8'hE2;
  localparam logic [7:0] OP_ROL = 8'hE3;
  localparam logic [7:0] OP_HLT = 8'hF0;

  // Flag vector layout {N,Z,C,B,V}
  localparam int F_N = 4;
  localparam int F_Z = 3;
  localparam int F_C = 2;
  localparam int F_B = 1;
  localparam int F_V = 0;

  typedef enum logic [3:0] {
    FETCH, FETCH_W, DECODE, OPND, OPND_W, DATA, DATA_W, EXEC, STORE, HALT
  } state_t;

  typedef enum logic [2:0] {
    K_NOP, K_ONE, K_JUMP, K_STA, K_DATA, K_HLT
  } kind_t;

  function automatic kind_t classify(input logic [7:0] ir);
    kind_t k;
    case (ir)
      OP_NOT, OP_SHR, OP_SHL, OP_ROR, OP_ROL:                 k = K_ONE;
      OP_JMP, OP_JN, OP_JP, OP_JV, OP_JNV, OP_JZ, OP_JNZ,
      OP_JC, OP_JNC, OP_JB, OP_JNB:                           k = K_JUMP;
      OP_STA:                                                 k = K_STA;
      OP_LDA, OP_ADD, OP_OR, OP_AND, OP_SUB:                  k = K_DATA;
`ifdef AHMES_XOR_EN
      OP_XOR:                                                 k = K_DATA;
`endif
      OP_HLT:                                                 k = K_HLT;
      default:                                                k = K_NOP;
    endcase
    return k;
  endfunction

  function automatic logic [3:0] alu_op_of(input logic [7:0] ir);
    logic [3:0] op;
    case (ir)
      OP_ADD:  op = ALU_ADD;
      OP_SUB:  op = ALU_SUB;
      OP_OR:   op = ALU_OR;
      OP_AND:  op = ALU_AND;
      OP_NOT:  op = ALU_NOT;
      OP_XOR:  op = ALU_XOR;
      OP_ROL:  op = ALU_ROL;
      OP_ROR:  op = ALU_ROR;
      OP_SHL:  op = ALU_SHL;
      OP_SHR:  op = ALU_SHR;
      default: op = ALU_NOP;
    endcase
    return op;
  endfunction

  function automatic logic [4:0] flag_en_of(input logic [7:0] ir);
    logic [4:0] en;
    case (ir)
      OP_ADD:                                 en = 5'b11101;
      OP_SUB:                                 en = 5'b11011;
      OP_LDA, OP_OR, OP_AND, OP_NOT, OP_XOR:  en = 5'b11000;
      OP_ROL, OP_ROR, OP_SHL, OP_SHR:         en = 5'b11100;
      default:                                en = 5'b00000;
    endcase
    return en;
  endfunction

  function automatic logic jump_taken(input logic [7:0] ir, input logic [4:0] f);
    logic t;
    case (ir)
      OP_JMP:  t = 1'b1;
      OP_JN:   t = f[F_N];
      OP_JP:   t = ~f[F_N];
      OP_JV:   t = f[F_V];
      OP_JNV:  t = ~f[F_V];
      OP_JZ:   t = f[F_Z];
      OP_JNZ:  t = ~f[F_Z];
      OP_JC:   t = f[F_C];
      OP_JNC:  t = ~f[F_C];
      OP_JB:   t = f[F_B];
      OP_JNB:  t = ~f[F_B];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ahmes_flags.sv
// Ahmes {N,Z,C,B,V} flag register; each bit loads only when its enable is set.
module ahmes_flags
  import ahmes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] en,
  input  logic [4:0] d,
  output logic [4:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 5'b00000;
    else     q <= (q & ~en) | (d & en);
  end

endmodule

// File: rtl/ahmes_control.sv
// Ahmes multicycle control unit: fetch/decode/execute sequencer around an external memory and ALU.
// Opcode C0 is XOR only when AHMES_XOR_EN is defined (decode lives in ahmes_pkg).
module ahmes_control
  import ahmes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] mem_addr,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  input  logic [7:0] alu_result,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_borrow,  // ALU borrow flag; kept apart from the alu_b operand port
  input  logic       alu_v,
  output logic [4:0] flags,
  output logic [7:0] pc,
  output logic [7:0] ac,
  output logic       halted
);

  state_t     state;
  logic [7:0] ir, ea, mdr;
  kind_t      kind;
  logic       rd_req, wr_req;
  logic [4:0] flag_en, flag_d;

  always_comb begin
    kind     = classify(ir);
    mem_addr = pc;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    alu_op   = ALU_NOP;
    flag_en  = 5'b00000;
    flag_d   = {alu_n, alu_z, alu_c, alu_borrow, alu_v};
    case (state)
      FETCH, OPND: rd_req = 1'b1;
      DATA: begin
        mem_addr = ea;
        rd_req   = 1'b1;
      end
      STORE: begin
        mem_addr = ea;
        wr_req   = 1'b1;
      end
      DECODE: begin
        if (kind == K_ONE) begin
          alu_op  = alu_op_of(ir);
          flag_en = flag_en_of(ir);
        end
      end
      EXEC: begin
        alu_op  = alu_op_of(ir);
        flag_en = flag_en_of(ir);
        if (ir == OP_LDA) flag_d = {mdr[7], (mdr == 8'h00), 3'b000};
      end
      default: ;
    endcase
  end

  // State resets to FETCH, so strobes are masked while rst is held.
  assign mem_re    = rd_req & ~rst;
  assign mem_we    = wr_req & ~rst;
  assign mem_wdata = ac;
  assign alu_a     = ac;
  assign alu_b     = mdr;
  assign alu_cin   = flags[F_C];
  assign halted    = (state == HALT);

  ahmes_flags u_flags (
    .clk (clk),
    .rst (rst),
    .en  (flag_en),
    .d   (flag_d),
    .q   (flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= 8'h00;
      ac    <= 8'h00;
      ir    <= 8'h00;
      ea    <= 8'h00;
      mdr   <= 8'h00;
    end else begin
      case (state)
        FETCH:   state <= FETCH_W;
        FETCH_W: begin
          ir    <= mem_rdata;
          pc    <= pc + 8'd1;
          state <= DECODE;
        end
        DECODE: begin
          case (kind)
            K_ONE: begin
              ac    <= alu_result;
              state <= FETCH;
            end
            K_JUMP, K_STA, K_DATA: state <= OPND;
            K_HLT:                 state <= HALT;
            default:               state <= FETCH;
          endcase
        end
        OPND:    state <= OPND_W;
        OPND_W: begin
          ea <= mem_rdata;
          if (kind == K_JUMP) begin
            pc    <= jump_taken(ir, flags) ? mem_rdata : pc + 8'd1;
            state <= FETCH;
          end else begin
            pc    <= pc + 8'd1;
            state <= (kind == K_STA) ? STORE : DATA;
          end
        end
        DATA:    state <= DATA_W;
        DATA_W: begin
          mdr   <= mem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          ac    <= (ir == OP_LDA) ? mdr : alu_result;
          state <= FETCH;
        end
        STORE:   state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule
